// File: rtl/multdiv_seq_pkg.sv
// ---------------------------------------------------------------------------
// multdiv_seq_pkg
// Shared definitions for the sequential multiply/divide unit:
//   state_e    - controller state encoding (IDLE, MULT, DIV, DONE)
//   WIDTH_DEF  - default operand/result width
//   ITER_DEF   - default iteration count per operation (equals WIDTH_DEF)
//   INT_MIN    - most negative 32-bit signed value, the one dividend whose
//                quotient by -1 cannot be represented
// ---------------------------------------------------------------------------
package multdiv_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MULT = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam int WIDTH_DEF = 32;
  localparam int ITER_DEF  = 32;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/multdiv_seq_iter_counter.sv
// ---------------------------------------------------------------------------
// iter_counter
// Step counter for the multiply/divide sequencer.
//   clk     - clock, rising edge
//   reset   - asynchronous active-low reset, count forced to 0
//   clear   - synchronous clear to 0 (start of an operation)
//   enable  - advance by one step
//   tc      - terminal count: high while the count holds the last step index
//             (ITER-1), so the step taken on that edge is the final one
// ---------------------------------------------------------------------------
module iter_counter
  import multdiv_seq_pkg::*;
#(
  parameter int ITER = ITER_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int             CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0]  LAST = CW'(ITER - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);
  localparam logic [CW-1:0]  ZERO = CW'(0);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // next count: clear wins over enable
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = ZERO;
    end else if (enable) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == LAST);

endmodule

// File: rtl/multdiv_seq.sv
// ---------------------------------------------------------------------------
// multdiv_seq
// Iterative signed multiplier / divider for the execute stage.
// Multiply uses radix-2 Booth recoding, one step per cycle; divide uses
// restoring division on magnitudes, one quotient bit per cycle, with the
// sign applied on the final step. Both take ITER steps, so the result pulse
// arrives ITER+1 cycles after the cycle in which the start was presented.
// A zero divisor finishes after a single cycle with an exception.
//
// Ports:
//   clk             - clock, rising edge
//   reset           - asynchronous active-low reset
//   ctrl_MULT       - start multiply (takes priority over ctrl_DIV)
//   ctrl_DIV        - start divide
//   data_operandA   - multiplicand / dividend (signed)
//   data_operandB   - multiplier / divisor (signed)
//   data_result     - product low WIDTH bits or quotient, held until next DONE
//   data_exception  - product overflow, divide by zero, or INT_MIN / -1
//   data_resultRDY  - one-cycle pulse when result/exception are new
//   stall           - high while a start is presented or the unit is busy
// ---------------------------------------------------------------------------
module multdiv_seq
  import multdiv_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITER  = ITER_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             stall
);

  // Booth accumulator carries two guard bits so that adding or subtracting a
  // multiplicand of INT_MIN can never wrap before the arithmetic shift.
  localparam int UW = WIDTH + 2;
  // Booth register layout: {accumulator[UW], multiplier[WIDTH], q_minus1}
  localparam int BW = UW + WIDTH + 1;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W  = {WIDTH{1'b1}};
  localparam logic [UW-1:0]    ZERO_U  = {UW{1'b0}};

  // ---------------- state and datapath registers ----------------
  state_e           state_q,  state_d;
  logic [BW-1:0]    booth_q,  booth_d;
  logic [UW-1:0]    mcand_q,  mcand_d;
  logic [WIDTH-1:0] rem_q,    rem_d;
  logic [WIDTH-1:0] quot_q,   quot_d;
  logic [WIDTH-1:0] dvs_q,    dvs_d;
  logic             neg_q,    neg_d;
  logic             ovf_q,    ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q,    exc_d;
  logic             rdy_q,    rdy_d;

  // ---------------- combinational helpers ----------------
  logic [UW-1:0]    booth_acc_s;
  logic [UW-1:0]    booth_sum_s;
  logic [BW-1:0]    booth_nx_s;
  logic [WIDTH:0]   prod_hi_s;
  logic             mul_ovf_s;

  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] rem_nx_s;
  logic [WIDTH-1:0] quot_nx_s;
  logic [WIDTH-1:0] quot_fin_s;

  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;

  logic             cnt_clear;
  logic             cnt_en;
  logic             cnt_tc;

  iter_counter #(
    .ITER (ITER)
  ) u_iter_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .tc     (cnt_tc)
  );

  // one Booth radix-2 step: add/sub multiplicand per {q0, q-1}, then shift right arithmetically
  always_comb begin
    booth_acc_s = booth_q[BW-1:WIDTH+1];
    case (booth_q[1:0])
      2'b01:   booth_sum_s = booth_acc_s + mcand_q;
      2'b10:   booth_sum_s = booth_acc_s - mcand_q;
      default: booth_sum_s = booth_acc_s;
    endcase
    booth_nx_s = {booth_sum_s[UW-1], booth_sum_s, booth_q[WIDTH:1]};
    // product occupies booth_nx_s[2*WIDTH:1]; overflow when its upper WIDTH+1 bits disagree
    prod_hi_s  = booth_nx_s[2*WIDTH:WIDTH];
    mul_ovf_s  = !((&prod_hi_s) || !(|prod_hi_s));
  end

  // one restoring-division step on magnitudes, plus the signed quotient for the final step
  always_comb begin
    rem_sh_s = {rem_q, quot_q[WIDTH-1]};
    diff_s   = rem_sh_s - {1'b0, dvs_q};
    if (diff_s[WIDTH]) begin
      rem_nx_s  = rem_sh_s[WIDTH-1:0];
      quot_nx_s = {quot_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_nx_s  = diff_s[WIDTH-1:0];
      quot_nx_s = {quot_q[WIDTH-2:0], 1'b1};
    end
    if (neg_q) begin
      quot_fin_s = ZERO_W - quot_nx_s;
    end else begin
      quot_fin_s = quot_nx_s;
    end
  end

  // operand magnitudes for a divide start
  always_comb begin
    if (data_operandA[WIDTH-1]) begin
      a_mag_s = ZERO_W - data_operandA;
    end else begin
      a_mag_s = data_operandA;
    end
    if (data_operandB[WIDTH-1]) begin
      b_mag_s = ZERO_W - data_operandB;
    end else begin
      b_mag_s = data_operandB;
    end
  end

  // controller next-state and datapath next values
  always_comb begin
    state_d   = state_q;
    booth_d   = booth_q;
    mcand_d   = mcand_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    dvs_d     = dvs_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_MULT) begin
          state_d   = ST_MULT;
          mcand_d   = {{2{data_operandA[WIDTH-1]}}, data_operandA};
          booth_d   = {ZERO_U, data_operandB, 1'b0};
          cnt_clear = 1'b1;
        end else if (ctrl_DIV) begin
          state_d   = ST_DIV;
          rem_d     = ZERO_W;
          quot_d    = a_mag_s;
          dvs_d     = b_mag_s;
          neg_d     = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          // INT_MIN / -1: the magnitude path still yields INT_MIN, only the flag is extra
          ovf_d     = (data_operandA == MIN_VAL) && (data_operandB == ONES_W);
          cnt_clear = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_MULT: begin
        booth_d = booth_nx_s;
        cnt_en  = 1'b1;
        if (cnt_tc) begin
          state_d  = ST_DONE;
          rdy_d    = 1'b1;
          result_d = booth_nx_s[WIDTH:1];
          exc_d    = mul_ovf_s;
        end else begin
          state_d = ST_MULT;
        end
      end

      ST_DIV: begin
        if (dvs_q == ZERO_W) begin
          state_d  = ST_DONE;
          rdy_d    = 1'b1;
          result_d = ZERO_W;
          exc_d    = 1'b1;
        end else begin
          rem_d  = rem_nx_s;
          quot_d = quot_nx_s;
          cnt_en = 1'b1;
          if (cnt_tc) begin
            state_d  = ST_DONE;
            rdy_d    = 1'b1;
            result_d = quot_fin_s;
            exc_d    = ovf_q;
          end else begin
            state_d = ST_DIV;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // all controller and datapath state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      booth_q  <= {BW{1'b0}};
      mcand_q  <= ZERO_U;
      rem_q    <= ZERO_W;
      quot_q   <= ZERO_W;
      dvs_q    <= ZERO_W;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= ZERO_W;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      booth_q  <= booth_d;
      mcand_q  <= mcand_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvs_q    <= dvs_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  // stall must react in the same cycle a start is presented, so it is combinational;
  // it is gated by reset so it is low while reset is held
  always_comb begin
    stall = 1'b0;
    case (state_q)
      ST_IDLE: stall = reset & (ctrl_MULT | ctrl_DIV);
      ST_MULT: stall = reset;
      ST_DIV:  stall = reset;
      ST_DONE: stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// ---------------------------------------------------------------------------
// tb_multdiv_seq
// Directed vectors against the sequential multiply/divide unit. A reference
// model computes the expected product/quotient with plain 64-bit arithmetic
// and tracks only the externally visible timing (busy for ITER cycles, one
// cycle for a zero divisor, then a one-cycle ready). A compare process checks
// every output on every falling edge; each directed operation additionally
// checks its latency, result and exception against hand-computed literals.
// ---------------------------------------------------------------------------
module tb_multdiv_seq;
  import multdiv_seq_pkg::*;

  localparam int ITER_N = 32;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV  = 1'b0;
  logic [31:0] opa       = 32'h0;
  logic [31:0] opb       = 32'h0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        stall;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_left = 0;
  logic        m_rdy  = 1'b0;
  logic [31:0] m_res  = 32'h0;
  logic        m_exc  = 1'b0;
  logic [31:0] p_res  = 32'h0;
  logic        p_exc  = 1'b0;

  multdiv_seq #(
    .WIDTH (32),
    .ITER  (ITER_N)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (opa),
    .data_operandB  (opb),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .stall          (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // {exception, low 32 bits} of the full signed product
  function automatic logic [32:0] f_mul(input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [63:0] u;
    logic        e;
    p = longint'($signed(a)) * longint'($signed(b));
    u = p;
    e = !((u[63:31] == 33'h0) || (u[63:31] == 33'h1_FFFF_FFFF));
    return {e, u[31:0]};
  endfunction

  // {exception, quotient} of signed division truncating toward zero
  function automatic logic [32:0] f_div(input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    int q;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'h0) return {1'b1, 32'h0};
    if (a == INT_MIN && b == 32'hFFFF_FFFF) return {1'b1, INT_MIN};
    q = sa / sb;
    return {1'b0, 32'(q)};
  endfunction

  // reference model: accepts a start only when idle, then reports after the fixed latency
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left <= 0;
      m_rdy  <= 1'b0;
      m_res  <= 32'h0;
      m_exc  <= 1'b0;
    end else if (m_rdy) begin
      m_rdy <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_rdy <= 1'b1;
        m_res <= p_res;
        m_exc <= p_exc;
      end
    end else if (ctrl_MULT || ctrl_DIV) begin
      if (ctrl_MULT) begin
        {p_exc, p_res} <= f_mul(opa, opb);
        m_left <= ITER_N;
      end else begin
        {p_exc, p_res} <= f_div(opa, opb);
        m_left <= (opb == 32'h0) ? 1 : ITER_N;
      end
    end
  end

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = reset && ((m_left == 0 && !m_rdy && (ctrl_MULT || ctrl_DIV)) || m_left > 0);
    chk("cyc_rdy",    {31'h0, data_resultRDY}, {31'h0, m_rdy});
    chk("cyc_stall",  {31'h0, stall},          {31'h0, exp_stall});
    chk("cyc_result", data_result,             m_res);
    chk("cyc_exc",    {31'h0, data_exception}, {31'h0, m_exc});
  end

  // called just after a rising edge with the unit idle; the start is sampled on the next edge
  task automatic run_op(input string nm, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_res,
                        input logic exp_exc, input int repulse_at);
    int   n;
    logic got;
    ctrl_MULT = m;
    ctrl_DIV  = d;
    opa       = a;
    opb       = b;
    @(posedge clk);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    // operands change mid-operation; the unit must keep using the latched ones
    opa = ~a;
    opb = b ^ 32'h1357_9BDF;
    n   = 1;
    got = 1'b0;
    while (!got && n <= 40) begin
      ctrl_DIV = (n == repulse_at);
      @(negedge clk);
      if (data_resultRDY) begin
        got = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
    chk({nm, "_result"}, data_result, exp_res);
    chk({nm, "_exc"}, {31'h0, data_exception}, {31'h0, exp_exc});
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // power-on reset
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("por_result", data_result, 32'h0);
    chk("por_rdy",    {31'h0, data_resultRDY}, 32'h0);
    chk("por_stall",  {31'h0, stall}, 32'h0);
    reset = 1'b1;

    // start on the first edge after release
    run_op("mul_7_m6",    1'b1, 1'b0, 32'd7,          32'hFFFF_FFFA, 33, 32'hFFFF_FFD6, 1'b0, -1);
    run_op("mul_ovf",     1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000, 33, 32'h0000_0000, 1'b1, -1);
    run_op("div_m100_7",  1'b0, 1'b1, 32'hFFFF_FF9C,  32'd7,         33, 32'hFFFF_FFF2, 1'b0, -1);
    run_op("div_by_zero", 1'b0, 1'b1, 32'd5,          32'h0,          2, 32'h0000_0000, 1'b1, -1);
    run_op("div_min_m1",  1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 33, 32'h8000_0000, 1'b1, -1);
    run_op("both_3_4",    1'b1, 1'b1, 32'd3,          32'd4,         33, 32'd12,        1'b0, 10);
    run_op("mul_min_min", 1'b1, 1'b0, 32'h8000_0000,  32'h8000_0000, 33, 32'h0000_0000, 1'b1, -1);
    run_op("mul_m1_m1",   1'b1, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 33, 32'h0000_0001, 1'b0, -1);
    run_op("mul_neg_fit", 1'b1, 1'b0, 32'h0000_7FFF,  32'hFFFF_0000, 33, 32'h8001_0000, 1'b0, -1);
    run_op("mul_46341sq", 1'b1, 1'b0, 32'd46341,      32'd46341,     33, 32'h8000_1219, 1'b1, -1);
    run_op("div_100_m7",  1'b0, 1'b1, 32'd100,        32'hFFFF_FFF9, 33, 32'hFFFF_FFF2, 1'b0, -1);
    run_op("div_m7_2",    1'b0, 1'b1, 32'hFFFF_FFF9,  32'd2,         33, 32'hFFFF_FFFD, 1'b0, -1);
    run_op("div_7_100",   1'b0, 1'b1, 32'd7,          32'd100,       33, 32'h0000_0000, 1'b0, -1);
    run_op("div_min_1",   1'b0, 1'b1, 32'h8000_0000,  32'd1,         33, 32'h8000_0000, 1'b0, -1);
    run_op("mul_min_m1",  1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 33, 32'h8000_0000, 1'b1, -1);

    // abort a multiply at cycle 15 with an asynchronous reset
    ctrl_MULT = 1'b1;
    opa       = 32'd5;
    opb       = 32'd9;
    @(posedge clk);
    #1;
    ctrl_MULT = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_result", data_result, 32'h0);
    chk("arst_exc",    {31'h0, data_exception}, 32'h0);
    chk("arst_rdy",    {31'h0, data_resultRDY}, 32'h0);
    chk("arst_stall",  {31'h0, stall}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    run_op("post_rst_2_3", 1'b1, 1'b0, 32'd2, 32'd3, 33, 32'd6, 1'b0, -1);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multdiv_seq.md
MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Parameter: ITER, 32, iteration count per operation; SHALL equal WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 ctrl_MULT  input  1  start-multiply pulse, sampled on rising clk.
REQ-006 ctrl_DIV  input  1  start-divide pulse, sampled on rising clk.
REQ-007 data_operandA  input  WIDTH  signed operand A, from D/X latch A output; multiplicand/dividend.
REQ-008 data_operandB  input  WIDTH  signed operand B, from D/X latch B output; multiplier/divisor.
REQ-009 data_result  output  WIDTH  signed result; product low WIDTH bits or quotient.
REQ-010 data_exception  output  1  overflow or divide-by-zero flag; valid with data_resultRDY.
REQ-011 data_resultRDY  output  1  one-cycle pulse; result and exception valid.
REQ-012 stall  output  1  high while busy; drives D/X latch input_enable low and freezes upstream PC.

Function
REQ-013 States SHALL be IDLE, MULT, DIV, DONE.
REQ-014 IDLE: ctrl_MULT=1 -> MULT; else ctrl_DIV=1 -> DIV; operands latched internally on that edge; iteration counter cleared.
REQ-015 ctrl_MULT and ctrl_DIV both 1 in IDLE SHALL start a multiply; DIV ignored.
REQ-016 ctrl_MULT/ctrl_DIV SHALL be ignored in MULT, DIV and DONE; latched operands SHALL not change mid-operation.
REQ-017 MULT: one shift-add (Booth radix-2 permitted) step per cycle; after ITER steps -> DONE.
REQ-018 DIV: one restoring/non-restoring step per cycle on magnitudes; sign fixed in last step; after ITER steps -> DONE.
REQ-019 DIV with latched B = 0 SHALL go DIV -> DONE after one cycle; data_result = 0, data_exception = 1.
REQ-020 DONE: data_resultRDY = 1 for exactly one cycle; next state IDLE unconditionally.
REQ-021 Latency: start edge at cycle 0; data_resultRDY high during cycle ITER+1 (33) for non-zero-divisor operations.
REQ-022 Multiply result = low WIDTH bits of the full 2*WIDTH signed product; exception = 1 when the upper WIDTH+1 product bits are not all equal.
REQ-023 Divide quotient truncates toward zero; remainder discarded; exception = 0, except A = 0x80000000 and B = -1: result 0x80000000, exception 1.
REQ-024 data_result and data_exception SHALL hold their last DONE values until the next DONE.
REQ-025 stall = 1 combinationally in IDLE when either ctrl is 1, and in MULT and DIV; 0 in DONE and in IDLE with no start.

Reset
REQ-026 reset = 0 SHALL force IDLE immediately, independent of clk.
REQ-027 While in reset: data_result = 0, data_exception = 0, data_resultRDY = 0, stall = 0, counter = 0.
REQ-028 Reset mid-operation SHALL abort; no data_resultRDY pulse for the aborted operation.
REQ-029 First start SHALL be accepted on the first rising clk after reset deasserts.

Structure
REQ-030 The shared package SHALL hold the state encoding, WIDTH default, ITER default and the INT_MIN constant 0x80000000.
REQ-031 The iteration counter SHALL be a separate sub-module, iter_counter (clear, enable, terminal-count output).
REQ-032 Datapath registers use the same async-reset register style as the existing pipeline latches.

Verification
REQ-033 MULT, A=7, B=-6 -> RDY at cycle 33, result -42 (0xFFFFFFD6), exception 0, stall high cycles 0-32.
REQ-034 MULT, A=0x00010000, B=0x00010000 -> result 0, exception 1.
REQ-035 DIV, A=-100, B=7 -> RDY at cycle 33, result -14, exception 0.
REQ-036 DIV, A=5, B=0 -> RDY at cycle 2, result 0, exception 1; DIV, A=0x80000000, B=-1 -> result 0x80000000, exception 1.
REQ-037 ctrl_MULT and ctrl_DIV both 1 with A=3, B=4 -> result 12; ctrl_DIV re-pulsed at cycle 10 -> ignored, single RDY.
REQ-038 reset = 0 at cycle 15 of a MULT -> all outputs 0 asynchronously, no RDY; new MULT, A=2, B=3 after release -> result 6 at cycle 33.
